// File: rtl/adder_nbit_serial.sv
// adder_nbit_serial
// Multi-cycle adder: (a + b + carry_in) computed CHUNK bits per clock, with
// the inter-chunk carry held in a register so the combinational carry chain
// is only CHUNK+1 bits long.
//
// Parameters
//   NUM_BITS  operand / result width (>= 2)
//   CHUNK     bits added per clock; must divide NUM_BITS
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   start      in   request a new addition (accepted in IDLE or DONE)
//   a, b       in   operands, captured on the accepting edge
//   carry_in   in   carry into bit 0, captured on the accepting edge
//   busy       out  high while chunks are being added
//   done       out  one-cycle pulse when sum/carry_out/overflow update
//   sum        out  registered (a+b+carry_in) mod 2^NUM_BITS
//   carry_out  out  registered carry out of the MSB
//   overflow   out  registered two's-complement overflow
module adder_nbit_serial #(
  parameter int NUM_BITS = 16,
  parameter int CHUNK    = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int NCHUNK = NUM_BITS / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((NUM_BITS < 2) || ((NUM_BITS % CHUNK) != 0)) begin : g_bad_param
    $error("adder_nbit_serial: NUM_BITS=%0d must be >= 2 and divisible by CHUNK=%0d",
           NUM_BITS, CHUNK);
  end

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx;
  logic [NUM_BITS-1:0] a_q;
  logic [NUM_BITS-1:0] b_q;
  logic                cin_q;    // captured carry_in, kept for the result check
  logic                carry_q;  // ripple carry between chunks
  logic [NUM_BITS-1:0] acc;

  logic [CHUNK-1:0]    a_chunk;
  logic [CHUNK-1:0]    b_chunk;
  logic [CHUNK:0]      chunk_sum;
  logic [NUM_BITS-1:0] acc_next;
  logic                last_chunk;
  logic                accept;

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic signed_ovf(input logic signed [NUM_BITS-1:0] x,
                                      input logic signed [NUM_BITS-1:0] y,
                                      input logic signed [NUM_BITS-1:0] s);
    return (x[NUM_BITS-1] == y[NUM_BITS-1]) && (s[NUM_BITS-1] != x[NUM_BITS-1]);
  endfunction

  // Chunk datapath: one CHUNK+1-bit add whose MSB becomes the next carry.
  always_comb begin
    a_chunk    = a_q[idx*CHUNK +: CHUNK];
    b_chunk    = b_q[idx*CHUNK +: CHUNK];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    acc_next   = acc;
    acc_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    last_chunk = (idx == IDX_W'(NCHUNK - 1));
  end

  // DONE accepts a new start so operations can run back-to-back.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      acc       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            cin_q   <= carry_in;
            carry_q <= carry_in;
            idx     <= '0;
            acc     <= '0;
            state   <= S_ADD;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_ADD: begin
          acc     <= acc_next;
          carry_q <= chunk_sum[CHUNK];
          if (last_chunk) begin
            sum       <= acc_next;
            carry_out <= chunk_sum[CHUNK];
            overflow  <= signed_ovf(a_q, b_q, acc_next);
            state     <= S_DONE;
`ifndef SYNTHESIS
            assert ({chunk_sum[CHUNK], acc_next} ==
                    ({1'b0, a_q} + {1'b0, b_q} + {{NUM_BITS{1'b0}}, cin_q}))
            else $error("adder_nbit_serial: a=%h b=%h cin=%b -> carry_out=%b sum=%h",
                        a_q, b_q, cin_q, chunk_sum[CHUNK], acc_next);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_ADD);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_adder_nbit_serial.sv
module tb_adder_nbit_serial;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-chunk instance
  logic        start16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, co16, ov16;
  logic [15:0] sum16;

  // 8-bit / single-chunk instance
  logic        start8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  sum8;

  adder_nbit_serial #(.NUM_BITS(16), .CHUNK(4)) dut16 (
    .clk(clk), .n_rst(n_rst), .start(start16), .a(a16), .b(b16),
    .carry_in(cin16), .busy(busy16), .done(done16), .sum(sum16),
    .carry_out(co16), .overflow(ov16)
  );

  adder_nbit_serial #(.NUM_BITS(8), .CHUNK(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8),
    .carry_in(cin8), .busy(busy8), .done(done8), .sum(sum8),
    .carry_out(co8), .overflow(ov8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        co;
    logic        ov;
    bit          glitch;
  } vec_t;

  vec_t vecs[9];

  // One 16-bit addition: start for one cycle, scramble inputs afterwards,
  // optionally pulse start with a=FFFF during the add, then check results.
  task automatic op16(input vec_t v);
    int lat;
    int nbusy;
    @(negedge clk);
    a16 = v.a; b16 = v.b; cin16 = v.cin; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = ~v.a; b16 = ~v.b; cin16 = ~v.cin;
    nbusy = int'(busy16);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (v.glitch && k == 2) begin
        start16 = 1'b1; a16 = 16'hFFFF;
      end else begin
        start16 = 1'b0;
      end
      @(posedge clk); #1;
      if (done16) lat = k;
      else nbusy += int'(busy16);
    end
    start16 = 1'b0;
    chk("latency16", lat, 4);
    chk("busy_cycles16", nbusy, 4);
    chk("busy_at_done16", busy16, 0);
    chk("sum16", sum16, v.sum);
    chk("carry_out16", co16, v.co);
    chk("overflow16", ov16, v.ov);
    @(posedge clk); #1;
    chk("done_once16", done16, 0);
    chk("sum_hold16", sum16, v.sum);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic eco, input logic eov);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    chk("busy8_accept", busy8, 1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done8) lat = k;
    end
    chk("latency8", lat, 1);
    chk("sum8", sum8, es);
    chk("carry_out8", co8, eco);
    chk("overflow8", ov8, eov);
    @(posedge clk); #1;
    chk("done_once8", done8, 0);
  endtask

  initial begin
    int first_done;
    int second_done;
    int ndone;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    n_rst = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start8 = 1'b0;  a8 = '0;  b8 = '0;  cin8 = 1'b0;
    #1;
    chk("rst_busy16", busy16, 0);
    chk("rst_done16", done16, 0);
    chk("rst_sum16", sum16, 0);
    chk("rst_co_ov16", {co16, ov16}, 0);
    chk("rst_state8", {busy8, done8, co8, ov8, sum8}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst16", {busy16, done16}, 0);

    for (int i = 0; i < 9; i++) op16(vecs[i]);

    // Back-to-back with start held high: (1,2) then (3,4).
    @(negedge clk);
    a16 = 16'd1; b16 = 16'd2; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'd3; b16 = 16'd4;
    first_done = 0; second_done = 0;
    for (int k = 1; k <= 30 && second_done == 0; k++) begin
      @(posedge clk); #1;
      if (k == 6) chk("b2b_hold_first", sum16, 16'h0003);
      if (done16) begin
        if (first_done == 0) begin
          first_done = k;
          chk("b2b_sum_first", sum16, 16'h0003);
        end else begin
          second_done = k;
          chk("b2b_sum_second", sum16, 16'h0007);
        end
      end
      if (first_done != 0 && k == first_done + 1) start16 = 1'b0;
    end
    chk("b2b_first_edge", first_done, 4);
    chk("b2b_second_edge", second_done, 9);
    repeat (2) begin
      @(posedge clk); #1;
      chk("b2b_result_holds", {done16, busy16, sum16}, {2'b00, 16'h0007});
    end

    // Reset in cycle 2 of an add aborts it with no done pulse.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_sum", sum16, 0);
    chk("abort_co_ov", {co16, ov16}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      ndone += int'(done16) + int'(busy16);
    end
    chk("abort_no_done", ndone, 0);
    op16('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0});

    // Single-chunk instance.
    op8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    op8(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
